// File: rtl/muldiv_hilo_ctrl_if.sv
// muldiv_hilo_ctrl_if: EX-side request and HI/LO write/forwarding bundle for the mul/div sequencer.
interface muldiv_hilo_ctrl_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        stallreq;
  logic        busy;
  logic        w_hi_we;
  logic        w_lo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [65:0] hilo_bus;
  modport master (
    output start, op, src_a, src_b, cancel,
    input  stallreq, busy, w_hi_we, w_lo_we, hi_o, lo_o, hilo_bus
  );
  modport slave (
    input  start, op, src_a, src_b, cancel,
    output stallreq, busy, w_hi_we, w_lo_we, hi_o, lo_o, hilo_bus
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer writing HI/LO with a forwarding bus.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies (IDLE -> DONE); divides stay iterative.
module muldiv_hilo_ctrl #(
  parameter int ITER = 32
) (
  input logic clk,
  input logic resetn,
  muldiv_hilo_ctrl_if.slave bus
);
  localparam int CW = $clog2(ITER);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt;
  logic [1:0] op_q;
  logic [31:0] a_raw, b_raw, m, mag_a, mag_b, q_s, r_s;
  logic [63:0] r, r_step, prod, res;
  logic [32:0] add_sum, sh, diff;
  logic accept, fast_in, last, sa, sb, done, we;
  assign accept = bus.start & ~bus.cancel;
  assign mag_a = (~bus.op[0] & bus.src_a[31]) ? -bus.src_a : bus.src_a;
  assign mag_b = (~bus.op[0] & bus.src_b[31]) ? -bus.src_b : bus.src_b;
  assign last = cnt == CW'(ITER - 1);
  assign sa = ~op_q[0] & a_raw[31];
  assign sb = ~op_q[0] & b_raw[31];
  // r holds {acc, multiplier} for multiply (shift right) or {rem, quotient} for divide (shift left)
  assign add_sum = {1'b0, r[63:32]} + {1'b0, r[0] ? m : 32'd0};
  assign sh = r[63:31];
  assign diff = sh - {1'b0, m};
  assign r_step = op_q[1] ? (diff[32] ? {sh[31:0], r[30:0], 1'b0} : {diff[31:0], r[30:0], 1'b1})
                          : {add_sum, r[31:1]};
`ifdef MULDIV_FAST_MUL_EN
  assign fast_in = ~bus.op[1];
  assign prod = {{32{sa}}, a_raw} * {{32{sb}}, b_raw};
`else
  assign fast_in = 1'b0;
  assign prod = (sa ^ sb) ? -r : r;
`endif
  assign q_s = (sa ^ sb) ? -r[31:0] : r[31:0];
  assign r_s = sa ? -r[63:32] : r[63:32];
  assign res = ~op_q[1] ? prod : ~|b_raw ? {a_raw, 32'hFFFF_FFFF} : {r_s, q_s};
  assign done = state == DONE;
  assign we = done & ~bus.cancel;
  assign bus.stallreq = resetn & ((state == BUSY) | ((state == IDLE) & accept));
  assign bus.busy = state != IDLE;
  assign bus.w_hi_we = we;
  assign bus.w_lo_we = we;
  assign bus.hi_o = done ? res[63:32] : 32'd0;
  assign bus.lo_o = done ? res[31:0] : 32'd0;
  assign bus.hilo_bus = {we, we, bus.hi_o, bus.lo_o};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = accept ? (fast_in ? DONE : BUSY) : IDLE;
      BUSY:    state_d = bus.cancel ? IDLE : last ? DONE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      op_q <= 2'd0;
      a_raw <= 32'd0;
      b_raw <= 32'd0;
      m <= 32'd0;
      r <= 64'd0;
    end else if (state == IDLE && accept) begin
      cnt <= '0;
      op_q <= bus.op;
      a_raw <= bus.src_a;
      b_raw <= bus.src_b;
      m <= bus.op[1] ? mag_b : mag_a;
      r <= {32'd0, bus.op[1] ? mag_a : mag_b};
    end else if (state == BUSY) begin
      cnt <= cnt + 1'b1;
      r <= r_step;
    end
endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Iterative multiply/divide sequencer for the EX stage. It serves MULT, MULTU, DIV and DIVU.
- Accepts one operation, holds the pipeline with a stall request while it iterates, then writes the 64-bit result into the HI/LO register pair.
- Also drives the HI/LO forwarding bus so ID sees the fresh values in the same cycle as the write.

Parameters:
- ITER, 32, number of shift/subtract (or shift/add) iterations; fixed to the 32-bit operand width.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  EX presents a mul/div instruction this cycle
- op  in  2  00=MULT, 01=MULTU, 10=DIV, 11=DIVU
- src_a  in  32  rs value (multiplicand / dividend)
- src_b  in  32  rt value (multiplier / divisor)
- cancel  in  1  pipeline flush; abort the current operation
- stallreq  out  1  hold IF/ID/EX while high
- busy  out  1  state != IDLE
- w_hi_we  out  1  HI write enable (one-cycle pulse)
- w_lo_we  out  1  LO write enable (one-cycle pulse)
- hi_o  out  32  result upper word / remainder
- lo_o  out  32  result lower word / quotient
- hilo_bus  out  66  {w_hi_we, w_lo_we, hi_o, lo_o}; forwarding bus to ID

Behaviour:
- Reset (resetn=0, async): state=IDLE, counter=0. All outputs are 0, including hilo_bus.
- States: IDLE, BUSY, DONE.
- IDLE:
  - When start=1 and cancel=0: latch op and operands, convert signed operands to magnitudes, counter=0, go to BUSY.
  - stallreq = start & ~cancel, combinational, so the stall begins in the start cycle.
- BUSY:
  - One iteration per cycle; counter increments 0..ITER-1. After iteration ITER-1, go to DONE.
  - stallreq=1 throughout.
  - start is ignored while BUSY, since the pipeline is held.
- DONE:
  - stallreq=0.
  - w_hi_we=w_lo_we=1 for exactly this cycle, with hi_o/lo_o valid.
  - Next state is IDLE.
  - A start arriving in DONE is not accepted. EX advances this cycle, so start can only reach the block again from IDLE.
- Total latency: start cycle + 32 BUSY cycles, then the DONE cycle. stallreq is high for 33 cycles, and the write occurs in cycle 34.
- hi_o/lo_o are 0 in every state except DONE.
- Multiply: unsigned shift-add on magnitudes gives a 64-bit product. For MULT, negate the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
- Divide: restoring division on magnitudes. For DIV:
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero (src_b=0, DIV or DIVU): LO=32'hFFFF_FFFF, HI=src_a. The block still takes the full latency and raises no exception.
- Signed overflow (DIV 0x8000_0000 / 0xFFFF_FFFF): LO=0x8000_0000, HI=0.
- cancel:
  - In BUSY or DONE: next state IDLE, and no write pulse in that cycle. In DONE, cancel suppresses w_hi_we/w_lo_we combinationally.
  - cancel with start in IDLE: the operation is not accepted.
- resetn asserted mid-operation: immediate return to IDLE, with no write.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- When defined:
  - MULT/MULTU skip BUSY. IDLE goes straight to DONE using a single-cycle 33x33 signed multiply on the registered operands.
  - stallreq is high for 1 cycle; the write occurs in the 2nd cycle.
  - Divides are unchanged.
- When undefined: multiplies use the iterative path with the same 34-cycle timing as divides.

Test Plan:
- DIVU 100/7 -> stallreq high 33 cycles, then one-cycle w_hi_we=w_lo_we=1 with LO=14, HI=2, and hilo_bus={1,1,2,14}. busy=0 the following cycle.
- DIV 0xFFFF_FFF9(-7) / 2 -> LO=0xFFFF_FFFD(-3), HI=0xFFFF_FFFF(-1). Also DIV 0x8000_0000 / 0xFFFF_FFFF -> LO=0x8000_0000, HI=0.
- MULT 0xFFFF_FFFF * 0xFFFF_FFFF -> HI=0, LO=1. MULTU with the same operands -> HI=0xFFFF_FFFE, LO=1. Repeat with MULDIV_FAST_MUL_EN defined and check the 1-cycle stall.
- DIVU 5/0 -> LO=0xFFFF_FFFF, HI=5, with full 34-cycle timing.
- Start DIV, assert cancel at BUSY cycle 10 -> IDLE next cycle, stallreq=0, no write pulse. A new DIVU 9/3 then yields LO=3, HI=0.
- Pull resetn low at BUSY cycle 20 -> all outputs 0 asynchronously. After release, the next start behaves normally.
